// File: rtl/pin_access_pkg.sv
// pin_access_pkg: shared definitions for the PIN-entry access controller.
//   - state encoding (3-bit binary) and the FSM state type
//   - digit-count width, timer width, largest legal BCD digit
package pin_access_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
    localparam logic [2:0] S_LOCKED  = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = S_IDLE,
        COLLECT = S_COLLECT,
        CHECK   = S_CHECK,
        OPEN    = S_OPEN,
        FAIL    = S_FAIL,
        LOCKED  = S_LOCKED
    } state_t;

    localparam int         CNT_W   = 2;     // counts digits 0..3; the 4th completes the code
    localparam int         TMR_W   = 8;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_ok(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/pin_timer.sv
// pin_timer: loadable down-counter shared by the OPEN hold time and the
// optional lockout time.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over en)
//   en         : count down by one, stopping at zero
//   load_val   : value to load
//   zero       : count is zero
module pin_timer
    import pin_access_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pin_access_ctrl.sv
// pin_access_ctrl: Moore PIN-entry controller. Collects four BCD digits,
// compares them with PIN, holds door_open for OPEN_CYCLES on a match and
// locks out after MAX_TRIES consecutive failures.
//   clk, rst_n  : clock, async active-low reset
//   digit_valid : digit strobe
//   digit       : BCD digit, values above 9 ignored
//   cancel      : abort entry (wins over digit_valid)
//   door_open   : high in OPEN
//   pin_error   : one-cycle pulse in FAIL
//   alarm       : high in LOCKED
//   tries       : failed attempts since last success/unlock
// Build option: LOCK_TIMER_EN -- LOCKED times out after LOCK_CYCLES;
// without it LOCKED is left only by reset.
module pin_access_ctrl
    import pin_access_pkg::*;
#(
    parameter logic [15:0] PIN         = 16'h1234,
    parameter int          MAX_TRIES   = 3,
    parameter int          OPEN_CYCLES = 4,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       cancel,
    output logic       door_open,
    output logic       pin_error,
    output logic       alarm,
    output logic [1:0] tries
);

    localparam logic [1:0]       TRIES_MAX = 2'(MAX_TRIES);
    localparam logic [TMR_W-1:0] OPEN_LD   = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCK_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      code;
    logic             match;
    logic [1:0]       tries_inc;
    logic             lock_load, lock_run;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

    assign match     = (code == PIN);
    assign tries_inc = (tries == TRIES_MAX) ? tries : tries + 2'd1;

    // tries already holds the new count while in FAIL
`ifdef LOCK_TIMER_EN
    assign lock_load = (state == FAIL) && (tries == TRIES_MAX);
    assign lock_run  = (state == LOCKED);
`else
    assign lock_load = 1'b0;
    assign lock_run  = 1'b0;
`endif

    assign tmr_load = ((state == CHECK) && match) || lock_load;
    assign tmr_val  = lock_load ? LOCK_LD : OPEN_LD;
    assign tmr_en   = (state == OPEN) || lock_run;

    pin_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Outputs are set on the transition into the state that owns them,
    // so they are registered and track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            code      <= '0;
            tries     <= '0;
            door_open <= 1'b0;
            pin_error <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            pin_error <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (cancel) begin
                        state <= IDLE;
                        cnt   <= '0;
                        code  <= '0;
                    end else if (digit_valid && bcd_ok(digit)) begin
                        code <= {code[11:0], digit};
                        if (cnt == 2'd3) begin
                            state <= CHECK;
                            cnt   <= '0;
                        end else begin
                            state <= COLLECT;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    code <= '0;
                    if (match) begin
                        state     <= OPEN;
                        door_open <= 1'b1;
                    end else begin
                        state     <= FAIL;
                        pin_error <= 1'b1;
                        tries     <= tries_inc;
                    end
                end
                OPEN: begin
                    if (tmr_zero) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        tries     <= '0;
                    end
                end
                FAIL: begin
                    if (tries == TRIES_MAX) begin
                        state <= LOCKED;
                        alarm <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
`ifdef LOCK_TIMER_EN
                    if (tmr_zero) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                        tries <= '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_access_ctrl.sv
// Bench for pin_access_ctrl: per-cycle vector table, hand-written lockout
// and asynchronous-reset sequences, then random stimulus against a
// schedule-based reference model. Build with +define+LOCK_TIMER_EN to
// check the timed-lockout variant.
module tb_pin_access_ctrl;

    localparam logic [15:0] PIN         = 16'h1234;
    localparam int          MAX_TRIES   = 3;
    localparam int          OPEN_CYCLES = 4;
    localparam int          LOCK_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       digit_valid;
    logic [3:0] digit;
    logic       cancel;
    logic       door_open, pin_error, alarm;
    logic [1:0] tries;
    logic [4:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign obs = {door_open, pin_error, alarm, tries};

    pin_access_ctrl #(
        .PIN(PIN), .MAX_TRIES(MAX_TRIES),
        .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .cancel(cancel), .door_open(door_open), .pin_error(pin_error),
        .alarm(alarm), .tries(tries)
    );

    // ---------------- reference model ----------------
    // Once a code is complete the whole output future (check cycle, open
    // window or error pulse, lockout) is queued; inputs only count while
    // nothing is queued and the lock is not latched.
    typedef struct packed {
        logic       door;
        logic       err;
        logic       alarm;
        logic [1:0] tries;
    } out_t;

    int   m_digits[$];
    out_t m_sched[$];
    out_t m_cur;
    bit   m_acc;
    bit   m_locked;
    int   m_tries;

    function automatic out_t mk(input bit d, input bit e, input bit a, input int t);
        out_t o;
        o.door = d; o.err = e; o.alarm = a; o.tries = 2'(t);
        return o;
    endfunction

    function automatic void m_reset();
        m_digits.delete();
        m_sched.delete();
        m_cur    = mk(0, 0, 0, 0);
        m_acc    = 1'b1;
        m_locked = 1'b0;
        m_tries  = 0;
    endfunction

    function automatic void m_edge(input logic dv, input logic [3:0] d, input logic cn);
        int code, nt;
        if (m_acc) begin
            if (cn) m_digits.delete();
            else if (dv && d <= 4'd9) begin
                m_digits.push_back(int'(d));
                if (m_digits.size() == 4) begin
                    code = 0;
                    foreach (m_digits[i]) code = code * 16 + m_digits[i];
                    m_digits.delete();
                    m_sched.push_back(mk(0, 0, 0, m_tries));
                    if (code == int'(PIN)) begin
                        repeat (OPEN_CYCLES) m_sched.push_back(mk(1, 0, 0, m_tries));
                        m_tries = 0;
                    end else begin
                        nt = (m_tries + 1 > MAX_TRIES) ? MAX_TRIES : m_tries + 1;
                        m_sched.push_back(mk(0, 1, 0, nt));
                        m_tries = nt;
                        if (nt == MAX_TRIES) begin
`ifdef LOCK_TIMER_EN
                            repeat (LOCK_CYCLES) m_sched.push_back(mk(0, 0, 1, MAX_TRIES));
                            m_tries = 0;
`else
                            m_locked = 1'b1;
`endif
                        end
                    end
                end
            end
        end
        if (m_sched.size() > 0) begin
            m_cur = m_sched.pop_front();
            m_acc = 1'b0;
        end else if (m_locked) begin
            m_cur = mk(0, 0, 1, MAX_TRIES);
            m_acc = 1'b0;
        end else begin
            m_cur = mk(0, 0, 0, m_tries);
            m_acc = 1'b1;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: door/err/alarm/tries got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called at a falling edge: drive, let the rising edge happen, return
    // at the next falling edge where outputs are sampled.
    task automatic cyc(input logic dv, input logic [3:0] d, input logic cn);
        digit_valid = dv; digit = d; cancel = cn;
        @(posedge clk);
        m_edge(dv, d, cn);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'd0, 1'b0);
    endtask

    task automatic enter4(input logic [15:0] c);
        for (int k = 0; k < 4; k++) cyc(1'b1, c[15-4*k -: 4], 1'b0);
    endtask

    task automatic do_reset();
        digit_valid = 0; digit = 0; cancel = 0;
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       dv;
        logic [3:0] d;
        logic       cn;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic dv, input logic [3:0] d, input logic cn,
                     input bit ed, input bit ee, input bit ea, input int et);
        vec_t r;
        r.dv = dv; r.d = d; r.cn = cn; r.exp = {ed, ee, ea, 2'(et)};
        tbl.push_back(r);
    endtask

    initial begin
        int hi, lo, alarm_cyc;
        logic [15:0] pinv;
        logic dv, cn;
        logic [3:0] d;
        int r;

        pinv = PIN;
        digit_valid = 0; digit = 0; cancel = 0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check("reset", obs, 5'b0);
        rst_n = 1'b1;

        // correct PIN: door on 2 cycles after 4th strobe, 4 cycles; digit during OPEN lost
        v(1,1,0, 0,0,0,0); v(1,2,0, 0,0,0,0); v(1,3,0, 0,0,0,0); v(1,4,0, 0,0,0,0);
        v(0,0,0, 1,0,0,0); v(1,1,0, 1,0,0,0); v(0,0,0, 1,0,0,0); v(0,0,0, 1,0,0,0);
        v(0,0,0, 0,0,0,0);
        // single failure
        v(1,1,0, 0,0,0,0); v(1,2,0, 0,0,0,0); v(1,3,0, 0,0,0,0); v(1,5,0, 0,0,0,0);
        v(0,0,0, 0,1,0,1); v(0,0,0, 0,0,0,1);
        // cancel wins over digit, then correct code; success clears tries
        v(1,1,0, 0,0,0,1); v(1,2,0, 0,0,0,1); v(1,3,1, 0,0,0,1);
        v(1,1,0, 0,0,0,1); v(1,2,0, 0,0,0,1); v(1,3,0, 0,0,0,1); v(1,4,0, 0,0,0,1);
        v(0,0,0, 1,0,0,1); v(0,0,0, 1,0,0,1); v(0,0,0, 1,0,0,1); v(0,0,0, 1,0,0,1);
        v(0,0,0, 0,0,0,0);
        // invalid digit mid-entry ignored
        v(1,1,0, 0,0,0,0); v(1,4'hA,0, 0,0,0,0); v(1,2,0, 0,0,0,0); v(1,4'hF,0, 0,0,0,0);
        v(1,3,0, 0,0,0,0); v(1,4,0, 0,0,0,0);
        v(0,0,0, 1,0,0,0); v(0,0,0, 1,0,0,0); v(0,0,0, 1,0,0,0); v(0,0,0, 1,0,0,0);
        v(0,0,0, 0,0,0,0);

        foreach (tbl[i]) begin
            cyc(tbl[i].dv, tbl[i].d, tbl[i].cn);
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // lockout: alarm rises on the edge pin_error falls
        do_reset();
        for (int a = 0; a < 3; a++) begin
            enter4(16'h9999);
            idle(1);
            check($sformatf("lock_err%0d", a), obs, {3'b010, 2'(a + 1)});
            idle(1);
            check($sformatf("lock_after%0d", a), obs, (a < 2) ? {3'b000, 2'(a + 1)} : 5'b00111);
        end
        alarm_cyc = 1;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, pinv[15-4*k -: 4], 1'b0);
            if (door_open) hi++;
            if (alarm) alarm_cyc++;
        end
        for (int k = 0; k < 8; k++) begin
            idle(1);
            if (door_open) hi++;
            if (alarm) alarm_cyc++;
        end
        check_int("locked_no_door", hi, 0);
`ifdef LOCK_TIMER_EN
        for (int k = 0; k < 40 && alarm; k++) begin
            idle(1);
            if (alarm) alarm_cyc++;
        end
        check_int("lock_alarm_cycles", alarm_cyc, LOCK_CYCLES);
        check("lock_release", obs, 5'b00000);
`else
        lo = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (!alarm) lo++;
        end
        check_int("lock_terminal", lo, 0);
        check("lock_hold", obs, 5'b00111);
`endif

        // async reset during OPEN (tries=1 so a cleared value is visible)
        do_reset();
        enter4(16'h1235); idle(2);
        enter4(16'h1234); idle(1);
        check("open_pre", obs, 5'b10001);
        #2 rst_n = 1'b0;
        #1 check("arst_open", obs, 5'b00000);
        @(negedge clk); rst_n = 1'b1; m_reset();

        // async reset during COLLECT discards the partial code
        enter4(16'h1235); idle(2);
        cyc(1'b1, 4'd1, 1'b0); cyc(1'b1, 4'd2, 1'b0);
        check("collect_pre", obs, 5'b00001);
        #2 rst_n = 1'b0;
        #1 check("arst_collect", obs, 5'b00000);
        @(negedge clk); rst_n = 1'b1; m_reset();
        cyc(1'b1, 4'd3, 1'b0); cyc(1'b1, 4'd4, 1'b0);
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            if (door_open || pin_error) hi++;
        end
        check_int("arst_cnt_cleared", hi, 0);
        cyc(1'b0, 4'd0, 1'b1);
        enter4(16'h1234); idle(1);
        check("arst_then_open", obs, 5'b10000);
        idle(4);

        // random stimulus against the model
        do_reset();
        check("rand_reset", obs, {m_cur});
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                r  = int'($urandom_range(0, 9));
                dv = ($urandom_range(0, 2) != 0);
                cn = ($urandom_range(0, 29) == 0);
                if (r < 6 && m_digits.size() < 4) d = pinv[15-4*m_digits.size() -: 4];
                else if (r < 8)                   d = 4'($urandom_range(0, 9));
                else                              d = 4'($urandom_range(10, 15));
                cyc(dv, d, cn);
            end
            check($sformatf("rand%0d", n), obs, {m_cur});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_access_ctrl.md
# pin_access_ctrl

- Moore-style PIN-entry access controller.
- Collects four BCD digits and compares them with a parameterised PIN. It opens a door output for a fixed time on a match and locks out after repeated failures.
- It is the behavioural RTL stage that feeds the Yosys flow. Its synthesized netlist maps onto the delayed CMOS cell library (BUF/NOT/NAND/NOR/DFF) for gate-level simulation against this RTL.

## Interface
- PIN, 16'h1234, expected code, BCD; first digit in [15:12], last in [3:0]
- MAX_TRIES, 3, failed attempts before lockout, range 1..3
- OPEN_CYCLES, 4, cycles door_open stays high, range 1..255
- LOCK_CYCLES, 16, lockout duration when timer enabled, range 1..255

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- digit_valid  in  1  digit strobe; sampled each rising edge
- digit  in  4  BCD digit; values >9 are ignored
- cancel  in  1  abort current entry
- door_open  out  1  high while in OPEN
- pin_error  out  1  one-cycle pulse in FAIL
- alarm  out  1  high while in LOCKED
- tries  out  2  failed attempts since last success or unlock

## Operation
- **States:** IDLE, COLLECT, CHECK, OPEN, FAIL, LOCKED.
- **Reset (rst_n=0, immediate):** state=IDLE; all outputs 0; digit counter, buffer and timer cleared. Reset mid-entry or mid-lockout discards everything.
- **IDLE / COLLECT, accepting digits:**
  - A valid digit (digit_valid=1, digit≤9) shifts into the buffer and increments the digit count.
  - First digit: IDLE→COLLECT.
  - Fourth digit: →CHECK.
  - digit>9 with digit_valid=1: no effect.
- **cancel in IDLE or COLLECT:** clears buffer and count, goes to IDLE, tries unchanged. cancel and digit_valid in the same cycle: cancel wins.
- **CHECK (exactly 1 cycle):**
  - buffer==PIN → OPEN, timer loaded with OPEN_CYCLES−1.
  - Otherwise → FAIL.
- **OPEN:** door_open=1, timer counts down. At 0 → IDLE, tries cleared to 0.
- **FAIL (1 cycle):** pin_error=1, tries+1.
  - New tries==MAX_TRIES → LOCKED.
  - Otherwise → IDLE.
- **LOCKED:** alarm=1; tries holds MAX_TRIES; exit behaviour per Configuration.
- **Ignored inputs:** digit_valid and cancel are ignored in CHECK, OPEN, FAIL and LOCKED. Digits presented there are lost, not buffered.
- **Widths:** timer is 8 bits. tries saturates at MAX_TRIES and never wraps.

## Timing
- All outputs are registered from state and counters; no combinational input→output path.
- **Latency:** 4th digit sampled at edge N → CHECK after N → door_open or pin_error visible after edge N+1.
- door_open is high for exactly OPEN_CYCLES cycles, then low, with state=IDLE.
- pin_error is high for exactly one cycle.
- alarm rises at the same edge that pin_error falls on the final failed attempt.
- **RTL:** contains no # delays.
- **Gate-level netlist:** the cells add 1 time unit per gate and clock-to-Q. The bench drives inputs on the falling edge and samples outputs just before the rising edge, so RTL and netlist results compare cycle-for-cycle.

## Configuration
- **LOCK_TIMER_EN defined:**
  - Entering LOCKED loads the timer with LOCK_CYCLES−1.
  - At 0 → IDLE with alarm=0 and tries=0.
- **Not defined:**
  - LOCKED is terminal; only rst_n exits.
  - The timer is used for OPEN only.

## Structure
- **Shared package/header (pin_access_pkg):**
  - State encoding localparams, 3 bits, binary.
  - Digit count width.
  - Timer width (8).
  - BCD maximum (4'd9).
- **Sub-module pin_timer:**
  - 8-bit loadable down-counter with load, enable and zero flag.
  - Shared by OPEN and, when enabled, LOCKED.
  - Kept separate so its synthesized DFF/NAND count can be reported independently.

## Test plan
- **Correct PIN:** reset, enter 1,2,3,4 → pin_error=0; door_open high exactly 4 cycles starting 2 cycles after the 4th strobe; then IDLE, tries=0.
- **Single failure:** enter 1,2,3,5 → pin_error one-cycle pulse, tries=1, door_open stays 0.
- **Lockout:** three wrong codes (e.g. 9,9,9,9 ×3) → tries=3, alarm=1. Then enter 1,2,3,4 → no door_open.
  - With LOCK_TIMER_EN: alarm falls after 16 cycles, tries=0.
  - Without: alarm stays high until rst_n=0.
- **Cancel and invalid digits:**
  - Enter 1,2, then cancel together with digit 3 → IDLE, count cleared. Then 1,2,3,4 → door opens.
  - digit=4'hA strobed mid-entry → ignored; code still accepted.
- **Asynchronous reset mid-entry:** rst_n low between clock edges during COLLECT and during OPEN → outputs 0 immediately, state IDLE, tries 0.
- **Gate-level equivalence:** synthesize onto the delayed cell library and run scenarios 1–3 → outputs match RTL at every sample point.
